// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pkg
//  Brief    : Shared types and constants for the Hamming(7,4) checker.
//  Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  // Default width of the corrected-error counter
  localparam int c_cnt_w_default = 8;

  // Codeword bit i is Hamming position i+1. Each mask selects the positions
  // that one syndrome bit covers.
  localparam logic [6:0] c_s1_mask = 7'b1010101;  // positions 1,3,5,7
  localparam logic [6:0] c_s2_mask = 7'b1100110;  // positions 2,3,6,7
  localparam logic [6:0] c_s4_mask = 7'b1111000;  // positions 4,5,6,7

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SYND = 3'd2,
    CORR = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_syndrome
//  Brief    : Combinational syndrome, correction mask and data extraction
//             for one Hamming(7,4) codeword.
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [6:0] i_code,
  output logic [2:0] o_syndrome,
  output logic [6:0] o_mask,
  output logic [3:0] o_data
);

  logic [2:0] w_syn;
  logic [6:0] w_mask;

  // Syndrome {s4,s2,s1}, one-hot flip mask at bit S-1, corrected data nibble
  always_comb begin
    w_syn  = {^(i_code & c_s4_mask), ^(i_code & c_s2_mask), ^(i_code & c_s1_mask)};
    w_mask = 7'd0;
    if (w_syn != 3'd0) begin
      w_mask = 7'd1 << (w_syn - 3'd1);
    end
    o_syndrome = w_syn;
    o_mask     = w_mask;
    o_data     = {i_code[6] ^ w_mask[6], i_code[5] ^ w_mask[5],
                  i_code[4] ^ w_mask[4], i_code[2] ^ w_mask[2]};
  end

endmodule
`default_nettype wire

// File: rtl/hamming_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_seq_ctrl
//  Brief    : Sequenced Hamming(7,4) single-error corrector with result
//             registers and a saturating corrected-word counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_seq_ctrl
  import hamming_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_default
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       entrada_i,
  input  logic [6:0]       palabra_i,
  input  logic             clr_cnt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       data_o,
  output logic [2:0]       syndrome_o,
  output logic [6:0]       error_o,
  output logic             mismatch_o,
  output logic [3:0]       led_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_entrada;
  logic [6:0]       r_palabra;
  logic [2:0]       r_synd;
  logic [3:0]       r_data;
  logic [2:0]       r_synd_out;
  logic [6:0]       r_error;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_syndrome;
  logic [6:0]       w_mask;
  logic [3:0]       w_data;

  hamming_syndrome u_syndrome (
    .i_code     (r_palabra),
    .o_syndrome (w_syndrome),
    .o_mask     (w_mask),
    .o_data     (w_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status outputs; start_i only matters in IDLE
  always_comb begin
    w_next = r_state;
    busy_o = 1'b1;
    done_o = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_next = LOAD;
        end
      end
      LOAD:    w_next = SYND;
      SYND:    w_next = CORR;
      CORR:    w_next = DONE;
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the request operands on the accepting edge so later input
  // changes cannot disturb the transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entrada <= 4'd0;
      r_palabra <= 7'd0;
    end else if (r_state == IDLE && start_i) begin
      r_entrada <= entrada_i;
      r_palabra <= palabra_i;
    end
  end

  // Syndrome stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_synd <= 3'd0;
    end else if (r_state == SYND) begin
      r_synd <= w_syndrome;
    end
  end

  // Correction stage; results then hold until the next CORR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= 4'd0;
      r_synd_out <= 3'd0;
      r_error    <= 7'd0;
      r_mismatch <= 1'b0;
    end else if (r_state == CORR) begin
      r_data     <= w_data;
      r_synd_out <= r_synd;
      r_error    <= w_mask;
      r_mismatch <= (w_data != r_entrada);
    end
  end

  // Corrected-word counter: bumps on CORR->DONE, saturates, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cnt <= '0;
    end else if (r_state == CORR && r_synd != 3'd0 && r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign data_o     = r_data;
  assign led_o      = r_data;
  assign syndrome_o = r_synd_out;
  assign error_o    = r_error;
  assign mismatch_o = r_mismatch;
  assign err_cnt_o  = r_cnt;

endmodule
`default_nettype wire
